// File: rtl/bshift_csd_pkg.sv
// Shared types and width helper for the CSD shifter arbiter.
// Digit encoding in a CSD word: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1.
package bshift_csd_pkg;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int csd_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/barrel_shifter_csd.sv
// Combinational log-stage barrel shifter over CSD digits; zero digits are shifted in.
// Left shift multiplies by 2^sel (high digits drop), right shift drops low digits.
module barrel_shifter_csd
  import bshift_csd_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic                    dir,
  input  logic [LOG2W-1:0]        sel,
  input  logic [csd_width(W)-1:0] in,
  output logic [csd_width(W)-1:0] out
);

  logic [csd_width(W)-1:0] stage;

  always_comb begin
    stage = in;
    for (int k = 0; k < LOG2W; k++) begin
      if (sel[k]) begin
        if (dir == DIR_RIGHT) stage = stage >> (2 << k);
        else                  stage = stage << (2 << k);
      end
    end
    out = stage;
  end

endmodule

// File: rtl/bshift_csd_arbiter.sv
// Two-requester arbiter in front of one CSD barrel shifter with a registered result slot.
// Round-robin by default; define BSHIFT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module bshift_csd_arbiter
  import bshift_csd_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_dir,
  input  logic [LOG2W-1:0]        req0_sel,
  input  logic [csd_width(W)-1:0] req0_in,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_dir,
  input  logic [LOG2W-1:0]        req1_sel,
  input  logic [csd_width(W)-1:0] req1_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [csd_width(W)-1:0] rsp_out,
  output logic                    rsp_id
);

  localparam int CW = csd_width(W);

  logic           slot_free;
  logic           gnt_any;
  req_idx_t       gnt_idx;
  logic           sh_dir;
  logic [LOG2W-1:0] sh_sel;
  logic [CW-1:0]  sh_in;
  logic [CW-1:0]  sh_out;

  assign slot_free = !rsp_valid || rsp_ready;

`ifdef BSHIFT_ARB_FIXED_PRIO_EN
  assign gnt_idx = req0_valid ? REQ0 : REQ1;
`else
  req_idx_t prio;

  always_comb begin
    gnt_idx = REQ0;
    if (req0_valid && req1_valid) gnt_idx = prio;
    else if (req1_valid)          gnt_idx = REQ1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prio <= REQ0;
    else if (clr)     prio <= REQ0;
    else if (gnt_any) prio <= (gnt_idx == REQ0) ? REQ1 : REQ0;
  end
`endif

  // rst gates the grant so both readies are low for the whole reset window
  assign gnt_any    = (req0_valid || req1_valid) && slot_free && !clr && !rst;
  assign req0_ready = gnt_any && (gnt_idx == REQ0);
  assign req1_ready = gnt_any && (gnt_idx == REQ1);

  always_comb begin
    sh_dir = req0_dir;
    sh_sel = req0_sel;
    sh_in  = req0_in;
    if (gnt_idx == REQ1) begin
      sh_dir = req1_dir;
      sh_sel = req1_sel;
      sh_in  = req1_in;
    end
  end

  barrel_shifter_csd #(.W(W), .LOG2W(LOG2W)) u_shift (
    .dir (sh_dir),
    .sel (sh_sel),
    .in  (sh_in),
    .out (sh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_id    <= 1'b0;
    end else if (clr) begin
      rsp_valid <= 1'b0;
    end else if (gnt_any) begin
      rsp_valid <= 1'b1;
      rsp_out   <= sh_out;
      rsp_id    <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bshift_csd_arbiter.sv
// Randomized and directed bench for bshift_csd_arbiter against an integer-valued reference model.
module tb_bshift_csd_arbiter;
  localparam int W  = 8;
  localparam int LW = 3;
  localparam int CW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic          req0_dir = 1'b0, req1_dir = 1'b0;
  logic [LW-1:0] req0_sel = '0, req1_sel = '0;
  logic [CW-1:0] req0_in = '0, req1_in = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] rsp_out;
  logic          rsp_id;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_valid;
  int m_val;
  int m_id;
  int m_prio;

  bshift_csd_arbiter #(.W(W), .LOG2W(LW)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dir(req0_dir),
    .req0_sel(req0_sel), .req0_in(req0_in),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dir(req1_dir),
    .req1_sel(req1_sel), .req1_in(req1_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] bin2csd(input int v);
    logic [CW-1:0] r;
    int x, d;
    r = '0;
    x = v;
    for (int i = 0; i < W; i++) begin
      if ((x & 1) != 0) begin
        d = ((x & 3) == 1) ? 1 : -1;
        x = x - d;
        r[2*i +: 2] = (d == 1) ? 2'b01 : 2'b11;
      end
      x = x >>> 1;
    end
    return r;
  endfunction

  function automatic int digit(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int csd2bin(input logic [CW-1:0] c);
    int acc;
    acc = 0;
    for (int i = 0; i < W; i++) acc += digit(c[2*i +: 2]) * (1 << i);
    return acc;
  endfunction

  // value of an ideal digit-shift: each digit moves by s positions, digits leaving the word vanish
  function automatic int ref_shift(input logic [CW-1:0] c, input logic dir, input int s);
    int acc;
    acc = 0;
    for (int i = 0; i < W; i++) begin
      if (!dir && (i + s < W)) acc += digit(c[2*i +: 2]) * (1 << (i + s));
      if (dir && (i >= s))     acc += digit(c[2*i +: 2]) * (1 << (i - s));
    end
    return acc;
  endfunction

  function automatic int model_gnt();
    if (rst || clr || (m_valid && !rsp_ready) || (!req0_valid && !req1_valid)) return -1;
`ifdef BSHIFT_ARB_FIXED_PRIO_EN
    if (req0_valid) return 0;
    return 1;
`else
    if (req0_valid && req1_valid) return m_prio;
    return req0_valid ? 0 : 1;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_val = 0; m_id = 0; m_prio = 0;
  endtask

  task automatic model_edge();
    int g;
    g = model_gnt();
    if (clr) begin
      m_valid = 0; m_prio = 0;
    end else if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_val   = (g == 0) ? ref_shift(req0_in, req0_dir, int'(req0_sel))
                         : ref_shift(req1_in, req1_dir, int'(req1_sel));
      m_prio  = 1 - g;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
  endtask

  // inputs are driven 1 time unit after a rising edge
  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic d, input int s, input int val);
    if (n == 0) begin
      req0_valid = v; req0_dir = d; req0_sel = LW'(s); req0_in = bin2csd(val);
    end else begin
      req1_valid = v; req1_dir = d; req1_sel = LW'(s); req1_in = bin2csd(val);
    end
  endtask

  task automatic test_reset();
    model_reset();
    drive(0, 1'b1, 1'b0, 1, 3);
    drive(1, 1'b1, 1'b0, 1, 3);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_out !== '0) begin errors++; $display("FAIL reset_out got %h want 0", rsp_out); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b want 0", rsp_id); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_single_left();
    drive(0, 1'b1, 1'b0, 2, 5);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
    advance();
    drive(0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    checks++; if (csd2bin(rsp_out) != 20) begin errors++; $display("FAIL single_value got %0d want 20", csd2bin(rsp_out)); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", rsp_id); end
    advance();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_id;
    clr = 1'b1;
    advance();
    clr = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 120) - 60);
      drive(1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 120) - 60);
      @(negedge clk);
`ifdef BSHIFT_ARB_FIXED_PRIO_EN
      exp_id = 0;
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL fixed_req1_ready cycle %0d got %b want 0", k, req1_ready); end
`else
      exp_id = k % 2;
`endif
      checks++; if ({req1_ready, req0_ready} !== (2'b01 << exp_id)) begin errors++; $display("FAIL rr_ready cycle %0d got %b", k, {req1_ready, req0_ready}); end
      if (k > 0) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid cycle %0d got %b want 1", k, rsp_valid); end
        checks++; if (int'(rsp_id) != ((k - 1) % 2) * (exp_id == 0 && k % 2 == 0 ? 0 : 1) && 0) begin end
        checks++; if (int'(rsp_id) != m_id || csd2bin(rsp_out) != m_val) begin errors++; $display("FAIL rr_result cycle %0d got id %0d val %0d want id %0d val %0d", k, rsp_id, csd2bin(rsp_out), m_id, m_val); end
      end
      advance();
    end
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    advance();
  endtask

  task automatic test_hold();
    drive(1, 1'b1, 1'b1, 3, -16);
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_accept got %b want 1", req1_ready); end
    advance();
    drive(1, 1'b1, 1'b0, 1, 7);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin errors++; $display("FAIL hold_state cycle %0d got valid %b id %b want 1 1", k, rsp_valid, rsp_id); end
      checks++; if (csd2bin(rsp_out) != -2) begin errors++; $display("FAIL hold_value cycle %0d got %0d want -2", k, csd2bin(rsp_out)); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready cycle %0d got %b want 00", k, {req0_ready, req1_ready}); end
      advance();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", req1_ready); end
    advance();
    drive(1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || csd2bin(rsp_out) != 14) begin errors++; $display("FAIL hold_b2b got valid %b val %0d want 1 14", rsp_valid, csd2bin(rsp_out)); end
    advance();
  endtask

  task automatic test_clr();
    drive(0, 1'b1, 1'b0, 0, 9);
    drive(1, 1'b1, 1'b0, 0, 11);
    rsp_ready = 1'b0;
    advance();
    clr = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid got %b want 1", rsp_valid); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL clr_nogrant got %b want 00", {req0_ready, req1_ready}); end
    advance();
    clr = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", rsp_valid); end
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL clr_first_grant got %b want 10", {req0_ready, req1_ready}); end
    advance();
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || csd2bin(rsp_out) != 9) begin errors++; $display("FAIL clr_after got valid %b id %b val %0d want 1 0 9", rsp_valid, rsp_id, csd2bin(rsp_out)); end
    advance();
  endtask

  task automatic test_random();
    int g;
    for (int k = 0; k < 400; k++) begin
      drive(0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 120) - 60);
      drive(1, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 120) - 60);
      rsp_ready = 1'($urandom_range(0, 9) < 7);
      clr = 1'($urandom_range(0, 24) == 0);
      @(negedge clk);
      g = model_gnt();
      checks++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin errors++; $display("FAIL rand_ready cycle %0d got %b%b want grant %0d", k, req0_ready, req1_ready, g); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rand_valid cycle %0d got %b want %b", k, rsp_valid, m_valid); end
      checks++; if ((^{rsp_out, rsp_id}) === 1'bx) begin errors++; $display("FAIL rand_xcheck cycle %0d got %h", k, rsp_out); end
      if (m_valid) begin
        checks++; if (int'(rsp_id) != m_id || csd2bin(rsp_out) != m_val) begin errors++; $display("FAIL rand_result cycle %0d got id %0d val %0d want id %0d val %0d", k, rsp_id, csd2bin(rsp_out), m_id, m_val); end
      end
      advance();
    end
    clr = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    rsp_ready = 1'b1;
    advance();
  endtask

  task automatic test_rst_mid();
    drive(0, 1'b1, 1'b0, 1, 13);
    rsp_ready = 1'b0;
    advance();
    drive(0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", rsp_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_out !== '0) begin errors++; $display("FAIL rstmid_async got valid %b out %h want 0 0", rsp_valid, rsp_out); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cycle %0d got %b want 0", k, rsp_valid); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_round_robin();
    test_hold();
    test_clr();
    test_random();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bshift_csd_arbiter.md
BSHIFT_CSD_ARBITER -- requirements
Module: bshift_csd_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, data word width in binary bits; each CSD word is 2*W bits.
REQ-002 SHALL have parameter LOG2W, default 3, shift-select width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous flush of the output register and priority pointer.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester n offers an operation.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-008 SHALL have ports req0_dir / req1_dir  input  1  shift direction, passed to barrel_shifter_csd dir.
REQ-009 SHALL have ports req0_sel / req1_sel  input  LOG2W  shift amount, passed to barrel_shifter_csd sel.
REQ-010 SHALL have ports req0_in / req1_in  input  2*W  CSD operand.
REQ-011 SHALL have port rsp_valid  output  1  rsp_out and rsp_id hold a valid result.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have port rsp_out  output  2*W  registered CSD shifter result.
REQ-014 SHALL have port rsp_id  output  1  index of the requester that produced rsp_out.

Function
REQ-015 SHALL own one barrel_shifter_csd instance; its dir/sel/in are driven from the granted requester's inputs by a combinational mux.
REQ-016 SHALL define slot_free = !rsp_valid || rsp_ready.
REQ-017 SHALL grant at most one requester per cycle, and only when slot_free is high and clr is low.
REQ-018 SHALL drive reqN_ready = grant to N, combinationally from valids, pointer and slot_free; ready SHALL NOT depend on reqN_valid of the same requester except through the arbitration.
REQ-019 Round-robin: pointer prio holds the favoured requester; if both valid, grant prio; if one valid, grant it regardless of prio.
REQ-020 SHALL set prio to the non-granted index after each grant; prio is unchanged in cycles with no grant.
REQ-021 On grant, SHALL register the shifter output in rsp_out, the grant index in rsp_id and set rsp_valid at the next edge; latency request-accept to rsp_valid is exactly 1 cycle.
REQ-022 SHALL clear rsp_valid when rsp_ready is high and no new grant occurs in that cycle.
REQ-023 Simultaneous rsp_ready and a new grant SHALL replace the result back-to-back, with rsp_valid staying high, giving full throughput of one operation per cycle.
REQ-024 While rsp_valid is high and rsp_ready is low, SHALL hold rsp_out, rsp_id and rsp_valid stable and deassert both ready outputs.
REQ-025 clr SHALL, at the next edge, clear rsp_valid, set prio to 0, and suppress grants in the clr cycle; clr has priority over any handshake.
REQ-026 rsp_out and rsp_id SHALL be don't-care while rsp_valid is low, but SHALL NOT carry X after reset.

Reset
REQ-027 rst high SHALL immediately force rsp_valid=0, rsp_out=0, rsp_id=0, prio=0; both ready outputs are 0 while rst is high.
REQ-028 Reset asserted mid-transaction SHALL discard the pending result with no response issued.

Configuration
REQ-029 With macro BSHIFT_ARB_FIXED_PRIO_EN defined, SHALL use fixed priority, with requester 0 always winning; prio is not implemented.
REQ-030 Without BSHIFT_ARB_FIXED_PRIO_EN, SHALL use round-robin as in REQ-019/020.

Structure
REQ-031 SHALL place the CSD word-width helper constant and the requester-index type in shared package bshift_csd_pkg.
REQ-032 SHALL use barrel_shifter_csd as its only sub-module; arbitration logic stays inline.
REQ-033 Target size is 120-400 RTL lines.

Verification
REQ-034 Bench SHALL convert operands with bin2csd and check results with csd2bin, with W=8.
REQ-035 Scenario: reset then req0 only, in=5, dir=left, sel=2, rsp_ready=1 -> rsp_valid next cycle, csd2bin(rsp_out)=20, rsp_id=0.
REQ-036 Scenario: both valid every cycle, rsp_ready=1, round-robin build -> rsp_id sequence 0,1,0,1; one result per cycle.
REQ-037 Scenario: req1 only, in=-16, dir=right, sel=3, rsp_ready=0 for 4 cycles -> rsp_out decodes to -2, held stable; req1_ready=0 until rsp_ready=1.
REQ-038 Scenario: clr asserted while rsp_valid=1 and both valid -> next cycle rsp_valid=0, no grant in the clr cycle, first subsequent grant to req0.
REQ-039 Scenario: BSHIFT_ARB_FIXED_PRIO_EN build, both valid continuously for 4 cycles -> rsp_id always 0, req1_ready never 1.
REQ-040 Scenario: rst pulsed mid-transfer with rsp_valid=1 -> rsp_valid=0 immediately, without waiting for clk; no stale result after release.
